// File: rtl/pixel_collector.sv
// pixel_collector: gathers RGB pixels from per-core FIFOs onto one valid/ready stream in strict round-robin core order.
// Latency: 1 cycle from a push into the selected, empty FIFO to out_valid (no fall-through).
// Backpressure: out_ready low holds the head stable; a full FIFO drops its in_ready. Define PIXCOL_FRAME_MARK_EN for SOF/EOL tags.

// Single-clock FIFO with an unreset storage array and a registered occupancy count.
module pixcol_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   push,
  input  logic [W-1:0]           data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  // Pixel storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge aclk) begin
    if (push) mem[wptr] <= data;
  end

  // Pointer and occupancy tracking; push and pop together leave the count unchanged.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];
endmodule

module pixel_collector #(
  parameter int NUM_CORES = 4,
  parameter int CHAN_W    = 8,
  parameter int DEPTH     = 4,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  localparam int EC_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [EC_W-1:0]               extra_cores,
  input  logic [NUM_CORES*3*CHAN_W-1:0] in_pixel,
  input  logic [NUM_CORES-1:0]          in_valid,
  output logic [NUM_CORES-1:0]          in_ready,
  output logic [3*CHAN_W-1:0]           out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_user,
  output logic                          out_last
);
  localparam int PIX_W = 3 * CHAN_W;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL   = CW'(DEPTH);
  localparam logic [EC_W:0]   NC     = (EC_W + 1)'(NUM_CORES);
  localparam logic [EC_W-1:0] EC_MAX = EC_W'(NUM_CORES - 1);

  // Reject parameter sets the FIFO pointer arithmetic and frame counters cannot handle.
  if (NUM_CORES < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IMG_W < 1 || IMG_H < 1) begin : g_param_chk
    $error("pixel_collector: illegal parameter set");
  end

  logic [EC_W-1:0]      ec_eff;
  logic [EC_W-1:0]      cur;
  logic                 cur_ok;
  logic                 xfer;
  logic [PIX_W-1:0]     head [NUM_CORES];
  logic [CW-1:0]        cnt  [NUM_CORES];
  logic [NUM_CORES-1:0] push;
  logic [NUM_CORES-1:0] pop;

  // Out-of-range core counts are clamped to the last physical core.
  assign ec_eff = ({1'b0, extra_cores} >= NC) ? EC_MAX : extra_cores;

  // A pointer left beyond the active range (after extra_cores was lowered) blocks output for one cycle.
  assign cur_ok    = (cur <= ec_eff);
  assign out_valid = cur_ok && (cnt[cur] != '0);
  assign out_data  = out_valid ? head[cur] : '0;
  assign xfer      = out_valid && out_ready;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    logic active;
    assign active      = (EC_W'(i) <= ec_eff);
    // No full-bypass: a full FIFO stays not-ready even while it is being popped.
    assign in_ready[i] = aresetn && active && (cnt[i] != FULL);
    assign push[i]     = in_valid[i] && in_ready[i];
    assign pop[i]      = xfer && (cur == EC_W'(i));

    pixcol_fifo #(
      .W     (PIX_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (push[i]),
      .data    (in_pixel[i*PIX_W +: PIX_W]),
      .pop     (pop[i]),
      .head    (head[i]),
      .count   (cnt[i])
    );
  end

  // Round-robin pointer: advances only on a transfer, wraps after the last active core.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur <= '0;
    end else if (!cur_ok) begin
      cur <= '0;
    end else if (xfer) begin
      cur <= (cur >= ec_eff) ? '0 : cur + 1'b1;
    end
  end

`ifdef PIXCOL_FRAME_MARK_EN
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // Raster position of the pixel currently at the output; moves only on a transfer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x <= '0;
      y <= '0;
    end else if (xfer) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign out_user = out_valid && (x == '0) && (y == '0);
  assign out_last = out_valid && (x == X_LAST);
`else
  assign out_user = 1'b0;
  assign out_last = 1'b0;
`endif
endmodule

// File: tb/tb_pixel_collector.sv
// tb_pixel_collector: randomized and directed stimulus checked cycle by cycle against a queue-based round-robin model.
// The model holds one queue per core plus the index of the core whose turn it is and the number of pixels sent.
// Expected frame tags are derived from the transfer count modulo the frame geometry.
module tb_pixel_collector;
  localparam int NC     = 4;
  localparam int CHAN_W = 8;
  localparam int DEPTH  = 4;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int PIX_W  = 3 * CHAN_W;
  localparam int EC_W   = 2;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic [EC_W-1:0]       extra_cores;
  logic [NC*PIX_W-1:0]   in_pixel;
  logic [NC-1:0]         in_valid;
  logic [NC-1:0]         in_ready;
  logic [PIX_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_user;
  logic                  out_last;

  int checks = 0;
  int errors = 0;

  logic [PIX_W-1:0] q [NC][$];
  int mcur  = 0;
  int nxfer = 0;

  pixel_collector #(
    .NUM_CORES (NC),
    .CHAN_W    (CHAN_W),
    .DEPTH     (DEPTH),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .extra_cores (extra_cores),
    .in_pixel    (in_pixel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_user    (out_user),
    .out_last    (out_last)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NC*PIX_W-1:0] rnd_pix();
    logic [NC*PIX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*PIX_W +: PIX_W] = PIX_W'($urandom);
    return r;
  endfunction

  function automatic int total();
    int s;
    s = 0;
    for (int i = 0; i < NC; i++) s += q[i].size();
    return s;
  endfunction

  // One clock cycle: drive, compare outputs with the model, advance the model past the next edge.
  task automatic step(input logic [NC-1:0] v, input logic [NC*PIX_W-1:0] pix, input logic ordy);
    int               eff;
    logic             ev;
    logic [PIX_W-1:0] ed;
    logic [PIX_W-1:0] popped;
    logic [NC-1:0]    rdy;
    in_valid  = v;
    in_pixel  = pix;
    out_ready = ordy;
    #1;
    eff = int'(extra_cores);
    ev  = (mcur <= eff) && (q[mcur].size() != 0);
    ed  = ev ? q[mcur][0] : '0;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", 32'(out_data), 32'(ed));
`ifdef PIXCOL_FRAME_MARK_EN
    chk("out_user", 32'(out_user), 32'(ev && (nxfer % (IMG_W * IMG_H) == 0)));
    chk("out_last", 32'(out_last), 32'(ev && (nxfer % IMG_W == IMG_W - 1)));
`else
    chk("out_user", 32'(out_user), 32'(0));
    chk("out_last", 32'(out_last), 32'(0));
`endif
    for (int i = 0; i < NC; i++) begin
      rdy[i] = (i <= eff) && (q[i].size() < DEPTH);
      chk($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(rdy[i]));
    end
    if (mcur > eff) begin
      mcur = 0;
    end else if (ev && ordy) begin
      popped = q[mcur].pop_front();
      nxfer++;
      mcur = (mcur >= eff) ? 0 : mcur + 1;
    end
    for (int i = 0; i < NC; i++)
      if (v[i] && rdy[i]) q[i].push_back(pix[i*PIX_W +: PIX_W]);
    @(posedge aclk);
    #2;
  endtask

  // Empties every queue, feeding a filler pixel to the current core when it is the one blocking.
  task automatic drain();
    int            n;
    logic [NC-1:0] v;
    n = 0;
    while (total() != 0 && n < 200) begin
      v = '0;
      if (mcur <= int'(extra_cores) && q[mcur].size() == 0) v[mcur] = 1'b1;
      step(v, rnd_pix(), 1'b1);
      n++;
    end
    chk("drain_empty", 32'(total()), 32'(0));
  endtask

  task automatic set_ec(input int v);
    drain();
    extra_cores = EC_W'(v);
  endtask

  initial begin
    logic [NC*PIX_W-1:0] p;
    int                  k;
    logic                acc;
    int                  ecs [5];

    extra_cores = 2'd3;
    in_valid    = '0;
    in_pixel    = '0;
    out_ready   = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_user", 32'(out_user), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    #11;
    aresetn = 1'b1;

    // Pushes arrive in core order 3,1,0,2; the stream must come out 1,2,3,4.
    p = {24'h040404, 24'h030303, 24'h020202, 24'h010101};
    step(4'b1000, p, 1'b1);
    step(4'b0010, p, 1'b1);
    step(4'b0001, p, 1'b1);
    step(4'b0100, p, 1'b1);
    repeat (4) step('0, p, 1'b1);

    // Single active core, stalled output: four pushes fill it, the fifth waits.
    set_ec(0);
    k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      p = '0;
      p[PIX_W-1:0] = 24'hA00000 + PIX_W'(k);
      acc = (q[0].size() < DEPTH);
      step(4'b0001, p, 1'b0);
      if (acc) k++;
    end
    chk("full_holds_fifth", 32'(k), 32'(4));
    for (int c = 0; c < 20 && k < 5; c++) begin
      p = '0;
      p[PIX_W-1:0] = 24'hA00000 + PIX_W'(k);
      acc = (q[0].size() < DEPTH);
      step(4'b0001, p, 1'b1);
      if (acc) k++;
    end
    chk("fifth_accepted", 32'(k), 32'(5));

    // Two active cores while the inactive ones keep requesting.
    set_ec(1);
    repeat (24) step('1, rnd_pix(), 1'b1);

    // Random traffic over several active-core counts, including lowering the count.
    ecs = '{3, 2, 1, 0, 3};
    foreach (ecs[j]) begin
      set_ec(ecs[j]);
      repeat (300) step(NC'($urandom), rnd_pix(), $urandom_range(0, 3) != 0);
    end

    // All cores fed continuously with out_ready toggling every cycle.
    set_ec(3);
    for (int c = 0; c < 200; c++) step('1, rnd_pix(), c[0] == 1'b0);

    // Reset in the middle of traffic with two pixels queued.
    set_ec(3);
    step(4'b0011, rnd_pix(), 1'b0);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_out_data", 32'(out_data), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
    chk("mid_rst_out_user", 32'(out_user), 32'(0));
    for (int i = 0; i < NC; i++) q[i].delete();
    mcur  = 0;
    nxfer = 0;
    @(posedge aclk);
    #1;
    chk("mid_rst_hold_ready", 32'(in_ready), 32'(0));
    #1;
    aresetn = 1'b1;
    step(4'b0001, rnd_pix(), 1'b0);
    step('0, rnd_pix(), 1'b1);
    repeat (150) step(NC'($urandom), rnd_pix(), $urandom_range(0, 1) == 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_collector.md
# pixel_collector

Parametrised pixel gather stage between the ray-tracing compute cores and the output video stream packer. It accepts RGB pixels from up to NUM_CORES cores, each through its own DEPTH-entry FIFO. It emits them on a single valid/ready stream in strict round-robin core order (core 0, 1, …, active count − 1, then wraps), which restores raster order for interleaved work distribution. Optionally it tags start-of-frame and end-of-line for the downstream AXI-Stream packer.

## Interface
Parameters:
- NUM_CORES, 4: number of core input ports, ≥1.
- CHAN_W, 8: bits per colour channel.
- DEPTH, 4: entries per core FIFO; power of two, ≥2.
- IMG_W, 640: pixels per line; used only with PIXCOL_FRAME_MARK_EN.
- IMG_H, 480: lines per frame; used only with PIXCOL_FRAME_MARK_EN.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- extra_cores  in  max(1,$clog2(NUM_CORES))  number of active cores minus 1. Values ≥ NUM_CORES are clamped to NUM_CORES−1.
- in_pixel  in  NUM_CORES*3*CHAN_W  core i occupies slice [i*3*CHAN_W +: 3*CHAN_W], packed {r,g,b}.
- in_valid  in  NUM_CORES  per-core pixel valid.
- in_ready  out  NUM_CORES  per-core ready; a push occurs when in_valid[i] & in_ready[i].
- out_data  out  3*CHAN_W  packed {r,g,b}.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream ready; a transfer occurs when out_valid & out_ready.
- out_user  out  1  start of frame; constant 0 without the macro.
- out_last  out  1  end of line; constant 0 without the macro.

## Operation
- Per-core FIFO: registered storage, write pointer, read pointer and count (width $clog2(DEPTH)+1).
- in_ready[i] = (count[i] != DEPTH) && (i <= extra_cores_eff). Inactive cores never get ready, and their FIFOs are never read.
- Full FIFO: in_ready is low even if a pop of the same FIFO happens in that cycle. There is no full-bypass.
- Empty FIFO: no fall-through. A pushed pixel becomes visible on the next cycle.
- Output selection:
  - Pointer cur, range 0..extra_cores_eff.
  - out_valid = (count[cur] != 0).
  - out_data = head of FIFO cur.
- On a transfer: pop FIFO cur. Then cur ← 0 if cur ≥ extra_cores_eff, else cur+1.
- If cur > extra_cores_eff (extra_cores lowered), cur ← 0 on the next cycle and no transfer occurs in that cycle.
- Upstream must change extra_cores only while all FIFOs are empty. Behaviour otherwise is defined only by the rules above (no data loss, but order is not guaranteed).
- A non-empty FIFO that is not cur simply waits. Head-of-line blocking is intended.
- Simultaneous push and pop on the same non-full FIFO: both occur and the count is unchanged.
- Reset (any time, including mid-frame):
  - All counts and pointers 0, cur=0, frame counters 0.
  - FIFO contents are discarded and storage is not cleared.
  - Outputs: in_ready=0 while aresetn is low, then per the rule above; out_valid=0, out_user=0, out_last=0, out_data=0.

## Timing
- Latency from push to out_valid: 1 cycle when FIFO cur is empty and selected.
- Sustained throughput: 1 pixel/cycle when every active FIFO is non-empty in turn.
- out_valid, once high, stays high with out_data, out_user and out_last stable until a transfer.
- All outputs are functions of registers only. There is no combinational path from out_ready or in_valid to any output.

## Configuration
- PIXCOL_FRAME_MARK_EN defined:
  - Adds column counter x (0..IMG_W−1) and row counter y (0..IMG_H−1).
  - Both advance only on an output transfer. x wraps to 0 and increments y; y wraps to 0 after line IMG_H−1.
  - out_user = out_valid && x==0 && y==0.
  - out_last = out_valid && x==IMG_W−1.
- Not defined: counters are absent, and out_user and out_last are tied to 0.

## Test plan
- NUM_CORES=4, extra_cores=3. Cores push 0x010101, 0x020202, 0x030303, 0x040404 in the order 3,1,0,2 -> output order is 0x010101, 0x020202, 0x030303, 0x040404. First out_valid appears 1 cycle after core 0's push.
- extra_cores=1, cores 2 and 3 driving in_valid=1 -> in_ready[3:2]=0. Output alternates core 0 and core 1 only; cur wraps 1→0.
- DEPTH=4, out_ready=0, core 0 pushes 5 pixels -> in_ready[0] drops after the 4th push and the 5th waits. Raising out_ready drains in push order.
- out_ready toggles 1010…, all FIFOs fed continuously -> no pixel lost or duplicated, and out_data is stable while out_valid && !out_ready.
- With macro, IMG_W=4, IMG_H=2, 8 transfers -> out_user on transfer 0 only; out_last on transfers 3 and 7; transfer 8 asserts out_user again.
- aresetn pulsed low mid-stream with 2 pixels queued -> out_valid=0 immediately. After release, output resumes with core 0's next new pixel, and with the macro out_user=1.
